// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - divided-clock phase/period checker
// Measures high/low phase lengths of an asynchronous divided clock in clk cycles and tracks lock.
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HIGH = 3,
  parameter int EXP_LOW  = 3,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_len,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_MAX - CNT_ONE;
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d, s_q, s_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_cur_q, hi_cur_d;
  logic [CNT_W-1:0] period_q, period_d, high_len_q, high_len_d;
  logic [3:0]       match_q, match_d, match_inc;
  logic             meas_valid_q, meas_valid_d, locked_q, locked_d;
  logic             err_q, err_d, timeout_q, timeout_d;
  logic             rise, fall, match_ok, phase_stuck;
  logic [CNT_W:0]   sum;

  function automatic logic in_tol(input logic [CNT_W-1:0] v, input int exp_v);
    int diff;
    diff = int'(v) - exp_v;
    return (diff <= TOL) && (diff >= -TOL);
  endfunction

  assign rise      = s_q & ~prev_q;
  assign fall      = ~s_q & prev_q;
  assign sum       = {1'b0, hi_cur_q} + {1'b0, cnt_q};
  assign match_ok  = in_tol(hi_cur_q, EXP_HIGH) && in_tol(cnt_q, EXP_LOW);
  assign match_inc = (match_q == LOCK_N) ? match_q : match_q + 4'd1;
  // A phase that would reach all-ones is treated as a stuck input.
  assign phase_stuck = (((state_q == HIGH) && !fall) || ((state_q == LOW) && !rise))
                       && (cnt_q == CNT_TOP);

  always_comb begin
    sync1_d      = div_in;
    s_d          = sync1_q;
    prev_d       = s_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_cur_d     = hi_cur_q;
    period_d     = period_q;
    high_len_d   = high_len_q;
    match_d      = match_q;
    locked_d     = locked_q;
    meas_valid_d = 1'b0;
    err_d        = 1'b0;
    timeout_d    = 1'b0;
    if (!en) begin
      state_d  = IDLE;
      match_d  = 4'd0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_cur_d = cnt_q;
            cnt_d    = CNT_ONE;
            state_d  = LOW;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        LOW: begin
          if (rise) begin
            period_d     = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
            high_len_d   = hi_cur_q;
            meas_valid_d = 1'b1;
            cnt_d        = CNT_ONE;
            state_d      = HIGH;
            if (match_ok) begin
              match_d  = match_inc;
              locked_d = locked_q | (match_inc == LOCK_N);
            end else begin
              err_d    = 1'b1;
              match_d  = 4'd0;
              locked_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (phase_stuck) begin
        timeout_d = 1'b1;
        locked_d  = 1'b0;
        match_d   = 4'd0;
        state_d   = SYNC;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      prev_q       <= 1'b0;
      cnt_q        <= '0;
      hi_cur_q     <= '0;
      period_q     <= '0;
      high_len_q   <= '0;
      match_q      <= 4'd0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      s_q          <= s_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      hi_cur_q     <= hi_cur_d;
      period_q     <= period_d;
      high_len_q   <= high_len_d;
      match_q      <= match_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_len   = high_len_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign timeout    = timeout_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - randomized bench for clk_div_monitor against a run-length model
// Two instances share stimulus: TOL=0 and TOL=1.
`timescale 1ns/1ps
module tb_clk_div_monitor;
  localparam int W = 8;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic div_in = 1'b0;
  logic [W-1:0] period_0, high_0, period_1, high_1;
  logic valid_0, locked_0, err_0, tout_0, valid_1, locked_1, err_1, tout_1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_valid0, n_err0, n_err1, n_to0, lock_at0, to_at;

  clk_div_monitor #(.CNT_W(W), .EXP_HIGH(3), .EXP_LOW(3), .LOCK_CNT(4), .TOL(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .div_in(div_in),
    .period(period_0), .high_len(high_0), .meas_valid(valid_0),
    .locked(locked_0), .err(err_0), .timeout(tout_0)
  );

  clk_div_monitor #(.CNT_W(W), .EXP_HIGH(3), .EXP_LOW(3), .LOCK_CNT(4), .TOL(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .div_in(div_in),
    .period(period_1), .high_len(high_1), .meas_valid(valid_1),
    .locked(locked_1), .err(err_1), .timeout(tout_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  logic cap_en = 1'b0, cap_div = 1'b0, cap_rst = 1'b0;
  always @(posedge clk) begin
    cap_en  <= en;
    cap_div <= div_in;
    cap_rst <= reset;
  end

  // Model: run lengths of the resynchronised input, armed once a rise is seen while enabled.
  bit hist [3];
  bit m_armed, m_en_seen, m_mv, m_to, m_s, m_p;
  int m_run, m_last, m_hi, m_period, m_high;
  int m_cnt [2];
  bit m_lock [2];
  bit m_err [2];

  task automatic model_clear();
    for (int i = 0; i < 3; i++) hist[i] = 1'b0;
    m_armed = 0; m_en_seen = 0; m_mv = 0; m_to = 0;
    m_run = 0; m_last = 0; m_hi = 0; m_period = 0; m_high = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_lock[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step();
    m_s = hist[1];
    m_p = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = cap_div;
    if (m_s != m_p) begin
      m_last = m_run;
      m_run  = 1;
    end else if (m_run < 100000) begin
      m_run++;
    end
    m_mv = 0; m_to = 0;
    for (int k = 0; k < 2; k++) m_err[k] = 0;
    if (!cap_en) begin
      m_en_seen = 0;
      m_armed   = 0;
      for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_lock[k] = 0; end
    end else if (!m_en_seen) begin
      m_en_seen = 1;
    end else if (m_s && !m_p) begin
      if (m_armed) begin
        m_mv     = 1;
        m_high   = m_hi;
        m_period = (m_hi + m_last > MAXC) ? MAXC : m_hi + m_last;
        for (int k = 0; k < 2; k++) begin
          if (iabs(m_hi - 3) <= k && iabs(m_last - 3) <= k) begin
            if (m_cnt[k] < 4) m_cnt[k]++;
          end else begin
            m_err[k] = 1;
            m_cnt[k] = 0;
          end
          m_lock[k] = (m_cnt[k] >= 4);
        end
      end
      m_armed = 1;
    end else if (!m_s && m_p) begin
      if (m_armed) m_hi = m_last;
    end else if (m_armed && m_run == MAXC) begin
      m_to    = 1;
      m_armed = 0;
      for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_lock[k] = 0; end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (!reset || !cap_rst) model_clear();
      else model_step();
      check("period0",  int'(period_0), m_mv || 1 ? m_period : 0);
      check("high0",    int'(high_0),   m_high);
      check("valid0",   int'(valid_0),  int'(m_mv));
      check("locked0",  int'(locked_0), int'(m_lock[0]));
      check("err0",     int'(err_0),    int'(m_err[0]));
      check("timeout0", int'(tout_0),   int'(m_to));
      check("period1",  int'(period_1), m_period);
      check("high1",    int'(high_1),   m_high);
      check("valid1",   int'(valid_1),  int'(m_mv));
      check("locked1",  int'(locked_1), int'(m_lock[1]));
      check("err1",     int'(err_1),    int'(m_err[1]));
      check("timeout1", int'(tout_1),   int'(m_to));
    end
  end

  task automatic step(input logic d);
    @(negedge clk);
    if (valid_0) begin
      n_valid0++;
      if (locked_0 && lock_at0 == 0) lock_at0 = n_valid0;
    end
    if (err_0) n_err0++;
    if (err_1) n_err1++;
    if (tout_0) begin n_to0++; to_at = cyc; end
    div_in = d;
    cyc++;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  task automatic clear_obs();
    n_valid0 = 0; n_err0 = 0; n_err1 = 0; n_to0 = 0; lock_at0 = 0; to_at = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period0"}, int'(period_0), 0);
    check({tag, "_high0"},   int'(high_0),   0);
    check({tag, "_valid0"},  int'(valid_0),  0);
    check({tag, "_locked0"}, int'(locked_0), 0);
    check({tag, "_err0"},    int'(err_0),    0);
    check({tag, "_tout0"},   int'(tout_0),   0);
    check({tag, "_period1"}, int'(period_1), 0);
    check({tag, "_locked1"}, int'(locked_1), 0);
  endtask

  initial begin
    int j;
    int r;
    clear_obs();
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    reset = 1'b1;
    en    = 1'b1;
    repeat (2) step(1'b0);

    clear_obs();
    wave(3, 3, 8);
    check("div6_lock_at", lock_at0, 4);
    check("div6_count",   n_valid0, 7);
    check("div6_errs",    n_err0,   0);
    check("div6_period",  int'(period_0), 6);
    check("div6_high",    int'(high_0),   3);

    clear_obs();
    j = cyc;
    repeat (300) step(1'b1);
    check("to_count",   n_to0, 1);
    check("to_latency", to_at - j, 257);
    check("to_locked",  int'(locked_0), 0);
    check("to_period",  int'(period_0), 6);

    clear_obs();
    wave(3, 3, 8);
    check("relock_at",   lock_at0, 4);
    check("relock_errs", n_err0,   0);

    clear_obs();
    wave(254, 2, 2);
    check("long_high",   int'(high_0),   254);
    check("long_period", int'(period_0), 255);
    check("long_to",     n_to0, 0);
    wave(200, 100, 3);
    check("sat_period",  int'(period_0), 255);
    check("sat_high",    int'(high_0),   200);

    wave(3, 3, 6);
    check("pre22_locked", int'(locked_0), 1);
    clear_obs();
    wave(2, 2, 6);
    check("d4_errs0",   n_err0, 5);
    check("d4_errs1",   n_err1, 0);
    check("d4_locked0", int'(locked_0), 0);
    check("d4_period",  int'(period_0), 4);
    check("d4_high",    int'(high_0),   2);

    wave(3, 3, 6);
    check("pre_dis_locked", int'(locked_0), 1);
    en = 1'b0;
    step(1'b0);
    check("dis_locked", int'(locked_0), 0);
    clear_obs();
    wave(3, 3, 2);
    check("dis_valid", n_valid0, 0);
    repeat (4) step(1'b1);
    en = 1'b1;
    clear_obs();
    repeat (2) step(1'b1);
    wave(3, 3, 3);
    check("reen_valid", n_valid0, 1);

    wave(3, 3, 4);
    repeat (3) step(1'b1);
    repeat (2) step(1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    #1 reset = 1'b1;
    clear_obs();
    wave(3, 3, 4);
    check("postrst_valid", n_valid0, 3);
    check("postrst_errs",  n_err0,   0);

    wave(4, 3, 6);
    check("tol1_period", int'(period_1), 7);
    check("tol1_high",   int'(high_1),   4);
    check("tol1_locked", int'(locked_1), 1);
    check("tol0_locked", int'(locked_0), 0);

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 8)) step(1'($urandom_range(0, 1)));
        en = 1'b1;
      end else if (r == 1) begin
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end else if (r == 2) begin
        wave($urandom_range(150, 270), $urandom_range(1, 4), 1);
      end else begin
        wave($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 4));
      end
    end
    repeat (5) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receive-side checker for divided clocks produced in the design, e.g. the divide-by-6 twisted-ring output.
- Samples a slow divided clock as data in the fast `clk` domain and measures its high-phase, low-phase and period lengths in `clk` cycles.
- Compares each measurement against expected values and reports lock, error and timeout status to the FIFO control/status logic.

Parameters:
- CNT_W, 8, width of the phase counters and of the period/high_len outputs.
- EXP_HIGH, 3, expected high-phase length in clk cycles.
- EXP_LOW, 3, expected low-phase length in clk cycles.
- LOCK_CNT, 4, consecutive matching periods required to assert locked (1..15).
- TOL, 0, allowed absolute deviation per phase in clk cycles.

Ports:
- clk, input, 1, fast reference clock; all logic is on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- en, input, 1, monitor enable; synchronous, level-sensitive.
- div_in, input, 1, divided clock under test, treated as asynchronous data.
- period, output, CNT_W, last measured period (high + low), clk cycles.
- high_len, output, CNT_W, last measured high-phase length.
- meas_valid, output, 1, one-cycle pulse when period/high_len update.
- locked, output, 1, LOCK_CNT consecutive in-tolerance periods seen.
- err, output, 1, one-cycle pulse with meas_valid when a measurement is out of tolerance.
- timeout, output, 1, one-cycle pulse when a phase counter saturates.

Behaviour:
- Reset (reset=0, asynchronous): all registers clear.
  - period=0, high_len=0, meas_valid=0, locked=0, err=0, timeout=0.
  - Synchronizer flops, prev and match counter cleared; state=IDLE.
- Input path: `div_in` passes through a 2-flop synchronizer to give `s`.
  - `prev` is `s` delayed by one cycle.
  - rise = s & ~prev; fall = ~s & prev.
- States: IDLE, SYNC, HIGH, LOW.
  - IDLE: `en=0` forces IDLE from any state on the next edge. locked clears, match counter clears, meas_valid/err/timeout are 0, period/high_len hold. `en=1` moves to SYNC.
  - SYNC: waits for rise. On rise: cnt<=1, go HIGH. No measurement is produced for this first edge. If `div_in` is already high when enabled, the block waits for the next rise.
  - HIGH: each cycle with s=1, cnt<=cnt+1. On fall: hi_cur<=cnt, cnt<=1, go LOW.
  - LOW: each cycle with s=0, cnt<=cnt+1. On rise:
    - period<=hi_cur+cnt, high_len<=hi_cur, meas_valid<=1.
    - cnt<=1, go HIGH.
- Counting: cnt equals the number of clk cycles `s` was in that phase. The sum hi_cur+cnt is computed at CNT_W+1 bits and saturates to all-ones on overflow.
- Latency: meas_valid is high in the cycle after the 3rd clk edge, counting the edge that first samples div_in=1 as edge 1.
- Check, evaluated with each meas_valid:
  - Match = |hi_cur-EXP_HIGH|<=TOL and |low-EXP_LOW|<=TOL.
  - Match: match counter increments, saturating at LOCK_CNT. locked<=1 in the same cycle the counter reaches LOCK_CNT.
  - Mismatch: err pulses with meas_valid, match counter<=0, locked<=0.
- Timeout: if cnt reaches all-ones in HIGH or LOW (stuck div_in):
  - timeout pulses for 1 cycle, locked<=0, match counter<=0, go SYNC.
  - period/high_len hold their previous values.
- Simultaneous events:
  - en=0 has priority over any edge or timeout in the same cycle.
  - Asynchronous reset overrides everything.
- Reset mid-operation: all state is discarded, with outputs as listed above. After release, measurement restarts from SYNC only once en=1.
- Glitches shorter than one clk cycle may be missed; this is accepted. Single-cycle phases are measured as length 1.

Test Plan:
- Div-by-6 source (3 high/3 low, synchronous to clk), en=1 after reset → meas_valid once every 6 cycles with period=6, high_len=3. err never pulses. locked rises on the 4th meas_valid (5th rise of div_in).
- Locked div-by-6, then switch source to 2 high/2 low → next meas_valid shows period=5 (transition period) or 4, with err=1 and locked drops same cycle. Afterwards every meas_valid has period=4, err=1; locked stays 0.
- TOL=1, source 4 high/3 low → period=7, high_len=4, no err; locked after 4 measurements.
- div_in held high 300 cycles after lock (CNT_W=8) → timeout pulses once, 254 cycles after the HIGH entry edge (cnt reaches 255). locked=0, state SYNC; period stays 6. Resuming div-by-6 relocks after 4 further measurements.
- en deasserted while locked → next cycle locked=0, no meas_valid. Re-enable while div_in high → first meas_valid appears only after one full period following the next rise.
- reset pulsed low mid-LOW phase → all outputs 0 immediately (asynchronous). After release with en=1, first meas_valid occurs one full period after the first rise, with no err.
